// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: program counter, instruction-memory handshake, skid buffer and IF/ID register.
// Redirects kill any in-flight response so the decode stage never sees a wrong-path word.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] fetch_addr_r, fetch_addr_s;
  logic [31:0] pending_r, pending_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic [31:0] skid_pc4_r, skid_pc4_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc4_r, pc4_s;
  logic        valid_r, valid_s;
  logic        redirect_s;
  logic        load_s;
  logic [31:0] target_s;
  logic [31:0] load_instr_s;
  logic [31:0] load_pc4_s;
  logic [31:0] fetch_inc_s;

  assign fetch_inc_s = fetch_addr_r + 32'd4;

  // Redirect detection and target selection (branch > jump-register > jump)
  always_comb begin
    redirect_s = BranchTaken | JumpReg | Jump;
    if (BranchTaken) begin
      target_s = BranchTarget;
    end else if (JumpReg) begin
      target_s = JumpRegTarget;
    end else begin
      target_s = {pc4_r[31:28], JumpIndex, 2'b00};
    end
  end

  // Fetch FSM: next state, fetch address, pending target and skid buffer
  always_comb begin
    state_s      = state_r;
    fetch_addr_s = fetch_addr_r;
    pending_s    = pending_r;
    skid_instr_s = skid_instr_r;
    skid_pc4_s   = skid_pc4_r;
    load_s       = 1'b0;
    load_instr_s = IMemData;
    load_pc4_s   = fetch_inc_s;
    case (state_r)
      INIT: begin
        state_s = REQ;
        if (redirect_s) begin
          fetch_addr_s = target_s;
        end else begin
          fetch_addr_s = fetch_addr_r;
        end
      end
      REQ: begin
        if (redirect_s) begin
          // A response arriving with the redirect is dropped; otherwise wait it out in KILL
          if (IMemReady) begin
            fetch_addr_s = target_s;
          end else begin
            pending_s = target_s;
            state_s   = KILL;
          end
        end else if (IMemReady) begin
          fetch_addr_s = fetch_inc_s;
          if (Stall) begin
            skid_instr_s = IMemData;
            skid_pc4_s   = fetch_inc_s;
            state_s      = HOLD;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_s = REQ;
        end
      end
      KILL: begin
        if (IMemReady) begin
          fetch_addr_s = redirect_s ? target_s : pending_r;
          state_s      = REQ;
        end else if (redirect_s) begin
          pending_s = target_s;
        end else begin
          state_s = KILL;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          fetch_addr_s = target_s;
          state_s      = REQ;
        end else if (!Stall) begin
          load_s       = 1'b1;
          load_instr_s = skid_instr_r;
          load_pc4_s   = skid_pc4_r;
          state_s      = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // IF/ID update: flush beats stall beats load
  always_comb begin
    instr_s = instr_r;
    pc4_s   = pc4_r;
    valid_s = valid_r;
    if (redirect_s | Flush) begin
      instr_s = 32'h0000_0000;
      valid_s = 1'b0;
    end else if (Stall) begin
      valid_s = valid_r;
    end else if (load_s) begin
      instr_s = load_instr_s;
      pc4_s   = load_pc4_s;
      valid_s = 1'b1;
    end else begin
      valid_s = valid_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r      <= INIT;
      fetch_addr_r <= RESET_PC;
      pending_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
      skid_pc4_r   <= 32'h0000_0000;
      instr_r      <= 32'h0000_0000;
      pc4_r        <= 32'h0000_0000;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_addr_r <= fetch_addr_s;
      pending_r    <= pending_s;
      skid_instr_r <= skid_instr_s;
      skid_pc4_r   <= skid_pc4_s;
      instr_r      <= instr_s;
      pc4_r        <= pc4_s;
      valid_r      <= valid_s;
    end
  end

  assign IMemReq     = (state_r == REQ) | (state_r == KILL);
  assign IMemAddr    = fetch_addr_r;
  assign Instruction = instr_r;
  assign OpCode      = instr_r[31:26];
  assign PCPlus4     = pc4_r;
  assign InstrValid  = valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run checked against
// an in-order instruction-stream scoreboard that restarts at every redirect target.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [25:0] JumpIndex = 26'h0;
  logic        JumpReg = 1'b0;
  logic [31:0] JumpRegTarget = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [5:0]  OpCode;
  logic [31:0] PCPlus4;
  logic        InstrValid;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_loads = 0;
  logic [63:0] expq[$];
  logic [31:0] tail_pc = 32'h0;
  logic [31:0] model_pc4 = 32'h0;
  bit          hash_mode = 1'b0;
  bit          rd_pend = 1'b0;

  instruction_fetch_unit #(.RESET_PC(RPC)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpIndex(JumpIndex),
    .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .Instruction(Instruction), .OpCode(OpCode), .PCPlus4(PCPlus4), .InstrValid(InstrValid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h0F0F_1234) : a;
  endfunction

  assign IMemData = IMemReady ? mem_word(IMemAddr, hash_mode) : 32'hDEAD_BEEF;

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (expq.size() < 16) begin
      expq.push_back({mem_word(tail_pc, hash_mode), tail_pc + 32'd4});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  task automatic reset_stream(input logic [31:0] t);
    expq.delete();
    tail_pc = t;
    refill();
  endtask

  // One clock edge; a redirect sampled on it restarts the expected stream at the architectural target
  task automatic tick();
    @(posedge Clk);
    if (rd_pend) begin
      if (BranchTaken) reset_stream(BranchTarget);
      else if (JumpReg) reset_stream(JumpRegTarget);
      else reset_stream({model_pc4[31:28], JumpIndex, 2'b00});
    end
    refill();
    #1;
    rd_pend = 1'b0;
    BranchTaken = 1'b0;
    Jump = 1'b0;
    JumpReg = 1'b0;
    Flush = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    IMemReady = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    BranchTaken = 1'b0;
    Jump = 1'b0;
    JumpReg = 1'b0;
    rd_pend = 1'b0;
    #2;
    chk("rst_req", 32'(IMemReq), 32'd0);
    chk("rst_addr", IMemAddr, RPC);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_opcode", 32'(OpCode), 32'd0);
    chk("rst_pc4", PCPlus4, 32'h0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    repeat (2) @(posedge Clk);
    model_pc4 = 32'h0;
    reset_stream(RPC);
    #1;
    Rst = 1'b0;
  endtask

  // Snapshot of pre-edge values for the monitor
  logic [31:0] s_instr, s_pc4, s_addr;
  logic        s_valid, s_stall, s_flush, s_wait;
  always @(posedge Clk) begin
    s_instr <= Instruction;
    s_pc4   <= PCPlus4;
    s_addr  <= IMemAddr;
    s_valid <= InstrValid;
    s_stall <= Stall;
    s_flush <= Flush | BranchTaken | Jump | JumpReg;
    s_wait  <= IMemReq & ~IMemReady;
  end

  // Monitor: every IF/ID load must be the next word of the expected stream
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (s_wait) chk("addr_stable", IMemAddr, s_addr);
        if (s_flush) begin
          chk("flush_instr", Instruction, 32'h0);
          chk("flush_valid", 32'(InstrValid), 32'd0);
          chk("flush_pc4", PCPlus4, s_pc4);
        end else if (s_stall) begin
          chk("stall_instr", Instruction, s_instr);
          chk("stall_pc4", PCPlus4, s_pc4);
          chk("stall_valid", 32'(InstrValid), 32'(s_valid));
        end else if (InstrValid && (!s_valid || Instruction != s_instr || PCPlus4 != s_pc4)) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_unexpected: got %h expected none", Instruction);
          end else begin
            e = expq.pop_front();
            chk("load_instr", Instruction, e[63:32]);
            chk("load_pc4", PCPlus4, e[31:0]);
            chk("load_opcode", 32'(OpCode), 32'(e[63:58]));
            model_pc4 = e[31:0];
            n_loads++;
          end
        end else begin
          chk("hold_instr", Instruction, s_instr);
          chk("hold_valid", 32'(InstrValid), 32'(s_valid));
        end
      end
    end
  end

  initial begin
    // Back-to-back fetch
    do_reset();
    IMemReady = 1'b1;
    tick();
    @(negedge Clk);
    chk("a_req", 32'(IMemReq), 32'd1);
    chk("a_addr0", IMemAddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge Clk);
      chk("a_instr", Instruction, 32'(4 * i));
      chk("a_pc4", PCPlus4, 32'(4 * i + 4));
      chk("a_valid", 32'(InstrValid), 32'd1);
      chk("a_addr", IMemAddr, 32'(4 * i + 4));
    end

    // Wait states on the request at 0x4
    do_reset();
    IMemReady = 1'b1;
    tick();
    tick();
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("b_addr", IMemAddr, 32'h4);
      chk("b_instr", Instruction, 32'h0);
      tick();
      if (i == 1) IMemReady = 1'b1;
    end
    Stall = 1'b1;
    @(negedge Clk);
    chk("b_instr4", Instruction, 32'h4);
    chk("b_pc4", PCPlus4, 32'h8);
    chk("b_addr8", IMemAddr, 32'h8);

    // Stall while 0x8 returns
    tick();
    @(negedge Clk);
    chk("c_req_hold", 32'(IMemReq), 32'd0);
    chk("c_instr", Instruction, 32'h4);
    chk("c_addr", IMemAddr, 32'hC);
    tick();
    Stall = 1'b0;
    @(negedge Clk);
    chk("c_req_hold2", 32'(IMemReq), 32'd0);
    chk("c_instr2", Instruction, 32'h4);
    tick();
    BranchTaken = 1'b1;
    BranchTarget = 32'h1000_0004;
    rd_pend = 1'b1;
    @(negedge Clk);
    chk("c_instr8", Instruction, 32'h8);
    chk("c_pc4", PCPlus4, 32'hC);
    chk("c_req", 32'(IMemReq), 32'd1);

    // Jump uses IF/ID PCPlus4 upper bits
    tick();
    @(negedge Clk);
    chk("d_br_addr", IMemAddr, 32'h1000_0004);
    chk("d_br_valid", 32'(InstrValid), 32'd0);
    tick();
    Jump = 1'b1;
    JumpIndex = 26'h40;
    rd_pend = 1'b1;
    @(negedge Clk);
    chk("d_pc4", PCPlus4, 32'h1000_0008);
    tick();
    BranchTaken = 1'b1;
    BranchTarget = 32'h10;
    rd_pend = 1'b1;
    @(negedge Clk);
    chk("d_j_addr", IMemAddr, 32'h1000_0100);
    chk("d_j_instr", Instruction, 32'h0);
    chk("d_j_valid", 32'(InstrValid), 32'd0);

    // Branch while the 0x10 request is in wait states
    tick();
    IMemReady = 1'b0;
    @(negedge Clk);
    chk("e_addr10", IMemAddr, 32'h10);
    tick();
    BranchTaken = 1'b1;
    BranchTarget = 32'h40;
    rd_pend = 1'b1;
    @(negedge Clk);
    chk("e_addr10w", IMemAddr, 32'h10);
    tick();
    IMemReady = 1'b1;
    @(negedge Clk);
    chk("e_kill_addr", IMemAddr, 32'h10);
    chk("e_kill_req", 32'(IMemReq), 32'd1);
    chk("e_kill_valid", 32'(InstrValid), 32'd0);
    tick();
    @(negedge Clk);
    chk("e_addr40", IMemAddr, 32'h40);
    chk("e_valid0", 32'(InstrValid), 32'd0);
    tick();
    IMemReady = 1'b0;
    @(negedge Clk);
    chk("e_instr40", Instruction, 32'h40);
    chk("e_pc4", PCPlus4, 32'h44);
    chk("e_valid1", 32'(InstrValid), 32'd1);

    // Asynchronous reset mid-request
    @(posedge Clk);
    #2;
    chk("f_req_before", 32'(IMemReq), 32'd1);
    do_reset();
    IMemReady = 1'b1;
    tick();
    @(negedge Clk);
    chk("f_addr", IMemAddr, RPC);
    chk("f_req", 32'(IMemReq), 32'd1);
    tick();
    @(negedge Clk);
    chk("f_instr", Instruction, mem_word(RPC, 1'b0));

    // Randomized traffic against the stream scoreboard
    hash_mode = 1'b1;
    do_reset();
    tick();
    repeat (3000) begin
      IMemReady = ($urandom_range(0, 2) != 0);
      Stall = ($urandom_range(0, 3) == 0);
      Flush = Stall && ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 11) == 0) begin
        BranchTaken = ($urandom_range(0, 2) == 0);
        JumpReg = ($urandom_range(0, 2) == 0);
        Jump = ($urandom_range(0, 1) == 0) || !(BranchTaken || JumpReg);
        BranchTarget = pick_target();
        JumpRegTarget = pick_target();
        JumpIndex = 26'($urandom());
        rd_pend = 1'b1;
      end
      tick();
    end
    @(negedge Clk);
    n_cmp++;
    if (n_loads < 500) begin
      n_bad++;
      $display("FAIL progress: got %0d loads expected at least 500", n_loads);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the MIPS datapath: holds the program counter, issues requests to instruction memory over a ready handshake, and captures returned words into the IF/ID register. Its `OpCode` output drives the datapath controller. It consumes the controller's resolved control flow (taken branch, jump, jump-register) from later stages and redirects fetch on it. It absorbs decode stalls, pipeline flushes and variable memory latency without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hold IF/ID; decode cannot accept.
- `Flush`  in  1  replace IF/ID contents with NOP.
- `BranchTaken`  in  1  resolved taken branch.
- `BranchTarget`  in  32  full branch target.
- `Jump`  in  1  J/JAL in decode.
- `JumpIndex`  in  26  instr_index field of the jump.
- `JumpReg`  in  1  JR in decode.
- `JumpRegTarget`  in  32  rs value for JR.
- `IMemReq`  out  1  fetch request valid.
- `IMemAddr`  out  32  fetch address, word aligned.
- `IMemReady`  in  1  memory returns `IMemData` this cycle.
- `IMemData`  in  32  instruction word.
- `Instruction`  out  32  IF/ID instruction.
- `OpCode`  out  6  `Instruction[31:26]`, to the controller.
- `PCPlus4`  out  32  IF/ID fetch address + 4.
- `InstrValid`  out  1  IF/ID holds a real instruction.

## Operation
- States:
  - INIT: after reset.
  - REQ: request outstanding.
  - KILL: outstanding request whose response must be discarded.
  - HOLD: response buffered in a skid register while stalled.
- `IMemReq` is 1 in REQ and KILL, and 0 in INIT and HOLD.
- `IMemAddr` equals the FetchAddr register. FetchAddr changes only on the edge where a request completes (`IMemReq & IMemReady`), on a redirect, or on reset.
- A redirect is any of `BranchTaken`, `JumpReg` or `Jump` sampled high. Priority is `BranchTaken` > `JumpReg` > `Jump`. Targets:
  - Branch: `BranchTarget`.
  - JR: `JumpRegTarget`.
  - J: {`PCPlus4[31:28]`, `JumpIndex`, 2'b00}, where `PCPlus4` is the current IF/ID value.
- There is no delay slot. Every redirect also flushes IF/ID.
- INIT -> REQ on the first edge after reset release.
- REQ, `IMemReady`=1, no redirect, `Stall`=0:
  - IF/ID ← {`IMemData`, FetchAddr+4, valid=1}.
  - FetchAddr ← FetchAddr+4.
  - Stay in REQ. Back-to-back fetch gives 1 instruction per cycle.
- REQ, `IMemReady`=1, `Stall`=1, no redirect:
  - skid ← {`IMemData`, FetchAddr+4}.
  - FetchAddr ← FetchAddr+4.
  - Go to HOLD.
- HOLD, `Stall`=0, no redirect: IF/ID ← skid with valid=1, then go to REQ.
- REQ, `IMemReady`=0, redirect: go to KILL and latch the target in a pending register. `IMemAddr` stays stable.
- KILL, `IMemReady`=1: discard `IMemData`, FetchAddr ← pending target, go to REQ.
- Redirect on the same edge as `IMemReady`=1 in REQ: discard the data, FetchAddr ← target, stay in REQ.
- Redirect in HOLD: discard the skid, FetchAddr ← target, go to REQ.
- A redirect in KILL overwrites the pending target.
- IF/ID update priority: redirect/`Flush` (NOP = 32'h0, `PCPlus4` unchanged, valid=0) > `Stall` (hold) > load.
- Without a load or flush, IF/ID holds its value. `InstrValid` is cleared by flush only.
- Address arithmetic is modulo 2^32. 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values (async, immediate on `Rst` high): state INIT, FetchAddr = `RESET_PC`, `IMemReq`=0, `Instruction`=0, `OpCode`=0, `PCPlus4`=0, `InstrValid`=0, skid and pending cleared.
- `Rst` during an outstanding request abandons it. `IMemReq` falls without waiting for a clock edge.
- `IMemReq` first rises one cycle after `Rst` deasserts.
- While `IMemReq`=1 and `IMemReady`=0, `IMemAddr` must not change.
- Latency from `IMemReady` to the `Instruction` update is one edge.
- Redirect penalty from the redirect edge:
  - 1 cycle to the new `IMemAddr` if no response is pending.
  - Otherwise the pending response latency plus one edge.
- All outputs are registered except `IMemReq` (state decode), `IMemAddr` (FetchAddr) and `OpCode` (slice).

## Test plan
- Release `Rst`, hold `IMemReady`=1, data = address → `IMemAddr` is 0, 4, 8 on consecutive cycles. `Instruction` is 0, 4, 8 one cycle later each, `PCPlus4` is 4, 8, 12, `InstrValid`=1.
- Request at 0x4 with `IMemReady` asserted in the 3rd cycle → `IMemAddr`=0x4 stable for 3 cycles. `Instruction` updates once, to 0x4.
- `Stall`=1 for 2 cycles while the response 0x8 arrives → IF/ID holds 0x4 and `IMemReq`=0 during HOLD. 0x8 loads on the first edge after the stall drops. No word is lost or repeated.
- IF/ID `PCPlus4`=0x1000_0008, `Jump`=1, `JumpIndex`=26'h40 → next `IMemAddr`=0x1000_0100. IF/ID becomes 0 with `InstrValid`=0.
- `BranchTaken`=1, `BranchTarget`=0x40 while a request at 0x10 has 2 wait states → the 0x10 data is discarded. Next `IMemAddr`=0x40, and `InstrValid` stays 0 until the 0x40 word loads.
- Assert `Rst` mid-request between clock edges → `IMemReq`=0, `IMemAddr`=`RESET_PC`, `Instruction`=0 immediately. Fetch restarts at `RESET_PC` after release.
